// File: rtl/duc_bypass_ctrl_if.sv
// duc_bypass_ctrl_if: config request, upstream stream, DUC input stream and DUC output monitor taps.
// master = the controller; slave = its environment (sample source, DUC, configuration agent).
// Pure wiring bundle, no latency and no state of its own.
interface duc_bypass_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic [2:0]            cfg_bypass_in;
    logic                  cfg_valid_in;
    logic                  cfg_ready_out;
    logic [DATA_WIDTH-1:0] up_data_in;
    logic                  up_valid_in;
    logic                  up_ready_out;
    logic [DATA_WIDTH-1:0] duc_data_out;
    logic                  duc_valid_out;
    logic                  duc_ready_in;
    logic                  mon_valid_in;
    logic                  mon_ready_in;
    logic [2:0]            bypass_out;
    logic                  busy_out;
    logic                  err_out;

    modport master (
        input  cfg_bypass_in, cfg_valid_in, up_data_in, up_valid_in,
               duc_ready_in, mon_valid_in, mon_ready_in,
        output cfg_ready_out, up_ready_out, duc_data_out, duc_valid_out,
               bypass_out, busy_out, err_out
    );

    modport slave (
        output cfg_bypass_in, cfg_valid_in, up_data_in, up_valid_in,
               duc_ready_in, mon_valid_in, mon_ready_in,
        input  cfg_ready_out, up_ready_out, duc_data_out, duc_valid_out,
               bypass_out, busy_out, err_out
    );
endinterface

// File: rtl/duc_bypass_ctrl.sv
// duc_bypass_ctrl: owns the DUC bypass word; a config request stops input, drains the DUC, waits for idle, applies.
// Latency: 0-cycle combinational passthrough in RUN; bypass changes on the edge leaving APPLY.
// Backpressure: up_ready_out mirrors duc_ready_in in RUN, forced low in every other state.
// Ports: clk/arst (async, active-high); bus = cfg req/ack, upstream in, DUC src out, DUC dst monitor,
//        bypass_out (registered), busy_out, err_out (sticky count underflow/overflow).
// Optional macro DUC_CTRL_ZERO_FLUSH_EN adds ZFLUSH: ZERO_FLUSH_SAMPLES zero beats pushed before draining.
module duc_bypass_ctrl #(
    parameter int         DATA_WIDTH         = 16,
    parameter int         CNT_WIDTH          = 12,
    parameter int         SETTLE_CYCLES      = 32,
    parameter int         ZERO_FLUSH_SAMPLES = 12,
    parameter logic [2:0] RESET_BYPASS       = 3'b000
) (
    input  logic              clk,
    input  logic              arst,
    duc_bypass_ctrl_if.master bus
);
    localparam int IDLE_W = $clog2(SETTLE_CYCLES + 1);

    // One gain-8 increment must fit beside a full counter in the CNT_WIDTH+1 sum.
    if (CNT_WIDTH < 4) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 4");
    end
    if (SETTLE_CYCLES < 1 || ZERO_FLUSH_SAMPLES < 1) begin : g_bad_counts
        $error("SETTLE_CYCLES and ZERO_FLUSH_SAMPLES must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_APPLY  = 3'd3
`ifdef DUC_CTRL_ZERO_FLUSH_EN
        , ST_ZFLUSH = 3'd4
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [2:0]            bypass_q, bypass_d;
    logic                  err_q, err_d;
`ifdef DUC_CTRL_ZERO_FLUSH_EN
    localparam int ZF_W = $clog2(ZERO_FLUSH_SAMPLES + 1);
    logic [ZF_W-1:0]       zf_q, zf_d;
`endif

    logic                  cfg_rdy, up_rdy, duc_vld;
    logic [DATA_WIDTH-1:0] duc_dat;
    logic                  in_beat, out_beat, dec;
    logic [1:0]            zero_bits;
    logic [CNT_WIDTH:0]    gain, sum;

    assign in_beat  = duc_vld & bus.duc_ready_in;
    assign out_beat = bus.mon_valid_in & bus.mon_ready_in;

    always_comb begin
        state_d  = state_q;
        bypass_d = bypass_q;
        idle_d   = '0;
        cfg_rdy  = 1'b0;
        up_rdy   = 1'b0;
        duc_vld  = 1'b0;
        duc_dat  = '0;
`ifdef DUC_CTRL_ZERO_FLUSH_EN
        zf_d     = zf_q;
`endif
        case (state_q)
            ST_RUN: begin
                // arst gating keeps both handshakes low while reset is held
                duc_vld = bus.up_valid_in & ~arst;
                duc_dat = bus.up_data_in;
                up_rdy  = bus.duc_ready_in & ~arst;
                if (bus.cfg_valid_in) begin
`ifdef DUC_CTRL_ZERO_FLUSH_EN
                    state_d = ST_ZFLUSH;
`else
                    state_d = ST_DRAIN;
`endif
                end
            end
`ifdef DUC_CTRL_ZERO_FLUSH_EN
            ST_ZFLUSH: begin
                duc_vld = 1'b1;
                if (bus.duc_ready_in) begin
                    if (zf_q == ZF_W'(ZERO_FLUSH_SAMPLES - 1)) begin
                        zf_d    = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        zf_d = zf_q + 1'b1;
                    end
                end
            end
`endif
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // any output beat restarts the idle window from zero
                if (!out_beat) begin
                    if (idle_q == IDLE_W'(SETTLE_CYCLES - 1)) state_d = ST_APPLY;
                    else                                        idle_d  = idle_q + 1'b1;
                end
            end
            ST_APPLY: begin
                cfg_rdy  = 1'b1;
                bypass_d = bus.cfg_bypass_in;
                state_d  = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outstanding DUC outputs: each accepted input yields 2^(number of active stages) outputs.
    always_comb begin
        zero_bits       = {1'b0, ~bypass_q[0]} + {1'b0, ~bypass_q[1]} + {1'b0, ~bypass_q[2]};
        gain            = '0;
        gain[zero_bits] = 1'b1;
        dec             = out_beat & (cnt_q != '0);
        sum             = {1'b0, cnt_q} + (in_beat ? gain : '0) - {{CNT_WIDTH{1'b0}}, dec};
        cnt_d           = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        err_d           = err_q | (out_beat & (cnt_q == '0)) | sum[CNT_WIDTH];
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            idle_q   <= '0;
            bypass_q <= RESET_BYPASS;
            err_q    <= 1'b0;
`ifdef DUC_CTRL_ZERO_FLUSH_EN
            zf_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            bypass_q <= bypass_d;
            err_q    <= err_d;
`ifdef DUC_CTRL_ZERO_FLUSH_EN
            zf_q     <= zf_d;
`endif
        end
    end

    assign bus.cfg_ready_out = cfg_rdy;
    assign bus.up_ready_out  = up_rdy;
    assign bus.duc_valid_out = duc_vld;
    assign bus.duc_data_out  = duc_dat;
    assign bus.bypass_out    = bypass_q;
    assign bus.busy_out      = (state_q != ST_RUN);
    assign bus.err_out       = err_q;
endmodule

// File: tb/tb_duc_bypass_ctrl.sv
// tb_duc_bypass_ctrl: directed scenarios plus a randomized run, all checked cycle by cycle
// against a behavioural model of the reconfiguration sequence kept in this file.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
module tb_duc_bypass_ctrl;
    localparam int DW      = 16;
    localparam int CW      = 12;
    localparam int SC      = 32;
    localparam int ZFN     = 12;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef DUC_CTRL_ZERO_FLUSH_EN
    localparam int ZF_CYC  = ZFN;
`else
    localparam int ZF_CYC  = 0;
`endif
    localparam int P_RUN = 0, P_ZF = 1, P_DRAIN = 2, P_SETTLE = 3, P_APPLY = 4;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    duc_bypass_ctrl_if #(.DATA_WIDTH(DW)) bus();

    duc_bypass_ctrl #(
        .DATA_WIDTH(DW), .CNT_WIDTH(CW), .SETTLE_CYCLES(SC),
        .ZERO_FLUSH_SAMPLES(ZFN), .RESET_BYPASS(3'b000)
    ) dut (
        .clk (clk),
        .arst(arst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model of the controller
    int         m_phase, m_cnt, m_idle, m_zf;
    logic       m_err;
    logic [2:0] m_byp;
    int         rdy_pulses;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int gain_of(input logic [2:0] b);
        return 1 << (3 - $countones(b));
    endfunction

    task automatic model_reset();
        m_phase = P_RUN; m_cnt = 0; m_idle = 0; m_zf = 0; m_err = 1'b0; m_byp = 3'b000;
    endtask

    task automatic set_in(input logic uv, input logic [DW-1:0] ud, input logic dr,
                          input logic mv, input logic mr);
        bus.up_valid_in  = uv;
        bus.up_data_in   = ud;
        bus.duc_ready_in = dr;
        bus.mon_valid_in = mv;
        bus.mon_ready_in = mr;
    endtask

    // Called right after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        logic          exp_up_rdy, exp_dv, inb, outb;
        logic [DW-1:0] exp_dd;
        int            nxt;
        #1;
        exp_up_rdy = (m_phase == P_RUN) && bus.duc_ready_in;
        exp_dv     = (m_phase == P_RUN) ? bus.up_valid_in : (m_phase == P_ZF);
        exp_dd     = (m_phase == P_RUN) ? bus.up_data_in : '0;
        check_eq("up_ready", 32'(bus.up_ready_out), 32'(exp_up_rdy));
        check_eq("duc_valid", 32'(bus.duc_valid_out), 32'(exp_dv));
        if (exp_dv) check_eq("duc_data", 32'(bus.duc_data_out), 32'(exp_dd));
        check_eq("busy", 32'(bus.busy_out), 32'(m_phase != P_RUN));
        check_eq("cfg_ready", 32'(bus.cfg_ready_out), 32'(m_phase == P_APPLY));
        check_eq("bypass", 32'(bus.bypass_out), 32'(m_byp));
        check_eq("err", 32'(bus.err_out), 32'(m_err));
        check_eq("cnt", 32'(dut.cnt_q), m_cnt);

        inb  = exp_dv && bus.duc_ready_in;
        outb = bus.mon_valid_in && bus.mon_ready_in;
        if (bus.cfg_ready_out) rdy_pulses++;
        if (outb && m_cnt == 0) m_err = 1'b1;
        nxt = m_cnt + (inb ? gain_of(m_byp) : 0) - ((outb && m_cnt > 0) ? 1 : 0);
        if (nxt > CNT_MAX) begin
            nxt   = CNT_MAX;
            m_err = 1'b1;
        end
        case (m_phase)
            P_RUN:    if (bus.cfg_valid_in) m_phase = (ZF_CYC > 0) ? P_ZF : P_DRAIN;
            P_ZF:     if (inb) begin
                          m_zf++;
                          if (m_zf == ZF_CYC) begin m_zf = 0; m_phase = P_DRAIN; end
                      end
            P_DRAIN:  if (m_cnt == 0) m_phase = P_SETTLE;
            P_SETTLE: if (outb) m_idle = 0;
                      else begin
                          m_idle++;
                          if (m_idle == SC) begin m_idle = 0; m_phase = P_APPLY; end
                      end
            P_APPLY:  begin m_byp = bus.cfg_bypass_in; m_phase = P_RUN; end
            default:  m_phase = P_RUN;
        endcase
        m_cnt = nxt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.cfg_valid_in = 1'b0;
        set_in(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        arst = 1'b1;
        #2;
        check_eq("rst_up_ready", 32'(bus.up_ready_out), 0);
        check_eq("rst_duc_valid", 32'(bus.duc_valid_out), 0);
        check_eq("rst_busy", 32'(bus.busy_out), 0);
        check_eq("rst_cfg_ready", 32'(bus.cfg_ready_out), 0);
        check_eq("rst_err", 32'(bus.err_out), 0);
        check_eq("rst_bypass", 32'(bus.bypass_out), 0);
        check_eq("rst_cnt", 32'(dut.cnt_q), 0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        arst = 1'b0;
    endtask

    // Full reconfiguration: output beats drain the DUC only while DRAIN is pending,
    // plus one optional extra beat in SETTLE when the idle count equals beat_at.
    task automatic request(input logic [2:0] b, input int beat_at,
                           output int lat, output int beats, output int beat_k);
        bit done = 1'b0;
        bit injected = 1'b0;
        lat = -1; beats = 0; beat_k = -1;
        bus.cfg_valid_in  = 1'b1;
        bus.cfg_bypass_in = b;
        for (int k = 0; k < 2000 && !done; k++) begin
            bit mv;
            mv = (m_phase == P_DRAIN) && (m_cnt > 0);
            if (m_phase == P_SETTLE && beat_at >= 0 && !injected && m_idle == beat_at) begin
                mv = 1'b1; injected = 1'b1; beat_k = k;
            end
            set_in(1'b0, '0, 1'b1, mv, 1'b1);
            if (mv) beats++;
            if (m_phase == P_APPLY) begin lat = k; done = 1'b1; end
            step();
            if (done) bus.cfg_valid_in = 1'b0;
        end
        check_eq("cfg_done", 32'(done), 1);
    endtask

    initial begin
        int lat, beats, bk;
        bit cfg_active;
        arst = 1'b1;
        bus.cfg_valid_in  = 1'b0;
        bus.cfg_bypass_in = 3'b000;
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        rdy_pulses = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // five samples at full gain, nothing leaves the DUC
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
            step();
        end
        check_eq("cnt_after_5", 32'(dut.cnt_q), 40);

        // reconfigure to full bypass from 40 outstanding
        rdy_pulses = 0;
        request(3'b111, -1, lat, beats, bk);
        check_eq("drain_beats", beats, 40 + ZF_CYC * 8);
        check_eq("lat_drain", lat, 1 + ZF_CYC + 40 + ZF_CYC * 8 + 1 + SC);
        check_eq("rdy_pulses", rdy_pulses, 1);
        check_eq("bypass_111", 32'(bus.bypass_out), 32'h7);
        set_in(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
        step();
        check_eq("gain1", 32'(dut.cnt_q), 1);

        // gain 2: lone input then simultaneous input/output
        request(3'b011, -1, lat, beats, bk);
        check_eq("bypass_011", 32'(bus.bypass_out), 32'h3);
        set_in(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
        step();
        check_eq("gain2", 32'(dut.cnt_q), 2);
        set_in(1'b1, DW'($urandom), 1'b1, 1'b1, 1'b1);
        step();
        check_eq("cnt_sim_beat", 32'(dut.cnt_q), 3);

        // same word again is fully sequenced, then empty-pipe minimum latency
        rdy_pulses = 0;
        request(3'b011, -1, lat, beats, bk);
        check_eq("lat_same", lat, 1 + ZF_CYC + 3 + ZF_CYC * 2 + 1 + SC);
        check_eq("rdy_same", rdy_pulses, 1);
        request(3'b000, -1, lat, beats, bk);
        check_eq("lat_empty", lat, 1 + ZF_CYC + ZF_CYC * 2 + 1 + SC);

        // output beat mid-SETTLE restarts the idle window (and underflows)
        request(3'b101, 20, lat, beats, bk);
        check_eq("settle_restart", lat - bk, SC + 1);
        check_eq("err_settle", 32'(bus.err_out), 1);

        // reset clears err; RUN-time underflow is sticky
        do_reset();
        set_in(1'b0, '0, 1'b1, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
            step();
        end
        check_eq("err_sticky", 32'(bus.err_out), 1);

        // saturation at the counter ceiling
        do_reset();
        for (int i = 0; i < 520; i++) begin
            set_in(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
            step();
        end
        check_eq("cnt_sat", 32'(dut.cnt_q), CNT_MAX);
        check_eq("err_sat", 32'(bus.err_out), 1);

        // reset in the middle of a drain
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
            step();
        end
        bus.cfg_valid_in  = 1'b1;
        bus.cfg_bypass_in = 3'b110;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
            step();
        end
        check_eq("busy_midop", 32'(bus.busy_out), 1);
        do_reset();
        check_eq("midop_cnt", 32'(dut.cnt_q), 0);

        // randomized traffic with occasional reconfiguration, some dropping cfg_valid early
        cfg_active = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            bit was_apply;
            logic mv;
            if (!cfg_active && m_phase == P_RUN && $urandom_range(0, 39) == 0) begin
                cfg_active        = 1'b1;
                bus.cfg_valid_in  = 1'b1;
                bus.cfg_bypass_in = 3'($urandom_range(0, 7));
            end else if (cfg_active && m_phase != P_RUN && $urandom_range(0, 59) == 0) begin
                bus.cfg_valid_in = 1'b0;
            end
            mv = (m_cnt > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 79) == 0);
            set_in(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 3) != 0),
                   mv, ($urandom_range(0, 3) != 0));
            was_apply = (m_phase == P_APPLY);
            step();
            if (was_apply) begin
                bus.cfg_valid_in = 1'b0;
                cfg_active       = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
